// File: rtl/bus_port_master.sv
// One driver slot on the open-drain wired-AND bus: drives the lanes for a settle
// window, samples the resolved bus, and reports where a written 1 was pulled low.
//
// state   | meaning
// IDLE    | slot released, ready for a request
// DRIVE   | write data on the lanes (reads stay released) while the settle counter runs
// RELEASE | turnaround cycle: lanes released, response pulse out
module bus_port_master #(
  parameter int W      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [W-1:0] req_data,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rsp_conflict,
  output logic [7:0]   conflict_count,
  output logic [W-1:0] drv_value,
  output logic [W-1:0] drv_enable,
  input  logic [W-1:0] bus_in
);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_write;
  logic [W-1:0] r_data;

  state_t       w_state_nxt;
  logic [3:0]   w_cnt_nxt;
  logic         w_write_nxt;
  logic [W-1:0] w_data_nxt;
  logic         w_sample;
  logic         w_drive;
  logic [W-1:0] w_conflict;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_write_nxt = r_write;
    w_data_nxt  = r_data;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = DRIVE;
          w_write_nxt = req_write;
          w_data_nxt  = req_data;
          w_cnt_nxt   = 4'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RELEASE;
          w_sample    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Outputs are registered, so the lane drive is decided from the next state.
    w_drive    = (w_state_nxt == DRIVE) && w_write_nxt;
    w_conflict = r_write ? (r_data & ~bus_in) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_write        <= 1'b0;
      r_data         <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_conflict   <= '0;
      conflict_count <= '0;
      drv_value      <= '1;
      drv_enable     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_write    <= w_write_nxt;
      r_data     <= w_data_nxt;
      req_ready  <= (w_state_nxt == IDLE);
      rsp_valid  <= w_sample;
      drv_enable <= w_drive ? '1 : '0;
      drv_value  <= w_drive ? w_data_nxt : '1;
      if (w_sample) begin
        rsp_data     <= bus_in;
        rsp_conflict <= w_conflict;
        if (r_write && (|w_conflict) && (conflict_count != 8'hFF))
          conflict_count <= conflict_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_port_master.sv
// Directed bench for bus_port_master (W=8, SETTLE=2) with a wired-AND bus model
// combining the slot's lanes with one external driver.
module tb_bus_port_master;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] rsp_conflict;
  logic [7:0] conflict_count;
  logic [7:0] drv_value;
  logic [7:0] drv_enable;
  logic [7:0] bus_in;
  logic [7:0] ext_drv;

  int n_checks = 0;
  int n_fail   = 0;

  bus_port_master #(.W(8), .SETTLE(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_conflict(rsp_conflict), .conflict_count(conflict_count),
    .drv_value(drv_value), .drv_enable(drv_enable),
    .bus_in(bus_in)
  );

  // Wired-AND: a lane is low if any enabled driver pulls it low.
  assign bus_in = (drv_value | ~drv_enable) & ext_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its response; reports latency (cycle index of
  // rsp_valid counted from the accept edge) and OR of drv_enable seen meanwhile.
  task automatic run_xact(input logic wr, input logic [7:0] d,
                          output logic [7:0] rd, output logic [7:0] cf,
                          output int lat, output logic [7:0] en_seen);
    bit acc = 0;
    bit got = 0;
    req_valid = 1'b1; req_write = wr; req_data = d;
    en_seen = '0; lat = 0; rd = '0; cf = '0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) acc = 1;
      tick();
    end
    req_valid = 1'b0;
    if (!acc) check("accept_timeout", 1, 0);
    lat = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      en_seen |= drv_enable;
      if (rsp_valid) begin
        got = 1; rd = rsp_data; cf = rsp_conflict;
      end else begin
        tick();
        lat++;
      end
    end
    if (!got) check("rsp_timeout", 1, 0);
    tick();
  endtask

  logic [7:0] rd, cf, en;
  int         lat;
  logic [7:0] exp_en [1:7];
  logic       exp_rv [1:7];
  logic       rv_seen;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_data = '0; ext_drv = 8'hFF;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_en", drv_enable, 8'h00);
    check("rst_val", drv_value, 8'hFF);
    check("rst_rv", rsp_valid, 0);
    check("rst_cnt", conflict_count, 0);
    check("rst_rdata", rsp_data, 0);

    // Uncontended write, cycle by cycle
    req_valid = 1'b1; req_write = 1'b1; req_data = 8'hA5;
    tick();
    req_valid = 1'b0;
    check("w1_en_c1", drv_enable, 8'hFF);
    check("w1_val_c1", drv_value, 8'hA5);
    check("w1_ready_c1", req_ready, 0);
    check("w1_rv_c1", rsp_valid, 0);
    tick();
    check("w1_en_c2", drv_enable, 8'hFF);
    check("w1_rv_c2", rsp_valid, 0);
    tick();
    check("w1_rv_c3", rsp_valid, 1);
    check("w1_en_c3", drv_enable, 8'h00);
    check("w1_rdata", rsp_data, 8'hA5);
    check("w1_conf", rsp_conflict, 8'h00);
    check("w1_cnt", conflict_count, 0);
    tick();
    check("w1_rv_c4", rsp_valid, 0);
    check("w1_ready_c4", req_ready, 1);
    check("w1_hold", rsp_data, 8'hA5);

    // Contended write, then saturation
    ext_drv = 8'h30;
    run_xact(1'b1, 8'hF0, rd, cf, lat, en);
    check("cw_rdata", rd, 8'h30);
    check("cw_conf", cf, 8'hC0);
    check("cw_cnt1", conflict_count, 1);
    check("cw_lat", lat, 3);
    for (int i = 1; i < 300; i++) run_xact(1'b1, 8'hF0, rd, cf, lat, en);
    check("cw_sat", conflict_count, 255);

    // Read never drives
    ext_drv = 8'h5A;
    run_xact(1'b0, 8'h00, rd, cf, lat, en);
    check("rd_en", en, 8'h00);
    check("rd_data", rd, 8'h5A);
    check("rd_conf", cf, 8'h00);
    check("rd_lat", lat, 3);
    check("rd_cnt", conflict_count, 255);

    // Back-to-back writes with req_valid held high
    ext_drv = 8'hFF;
    exp_en = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    exp_rv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    req_valid = 1'b1; req_write = 1'b1; req_data = 8'h11;
    tick();
    req_data = 8'h22;
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) req_valid = 1'b0;
      check($sformatf("b2b_en_c%0d", k), drv_enable, exp_en[k]);
      check($sformatf("b2b_rv_c%0d", k), rsp_valid, exp_rv[k]);
      if (k == 3) check("b2b_rdata1", rsp_data, 8'h11);
      if (k == 5) check("b2b_val2", drv_value, 8'h22);
      if (k == 7) check("b2b_rdata2", rsp_data, 8'h22);
      tick();
    end
    check("b2b_idle", req_ready, 1);

    // Reset mid-DRIVE
    req_valid = 1'b1; req_write = 1'b1; req_data = 8'h77;
    tick();
    req_valid = 1'b0;
    check("mid_en_pre", drv_enable, 8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_en", drv_enable, 8'h00);
    check("mid_val", drv_value, 8'hFF);
    check("mid_rv", rsp_valid, 0);
    check("mid_cnt", conflict_count, 0);
    check("mid_ready", req_ready, 1);
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rv_seen |= rsp_valid;
    end
    check("mid_no_pulse", rv_seen, 0);

    // Reset wins over a simultaneous request
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_data = 8'h0F;
    tick();
    reset = 1'b0; req_valid = 1'b0;
    tick();
    check("rw_en", drv_enable, 8'h00);
    check("rw_ready", req_ready, 1);
    tick();
    check("rw_rv", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_port_master.md
Name: bus_port_master

Overview:
- Sequential driver/sampler for one driver slot on the open-drain, wired-AND internal bus of the 6502 model.
- Accepts read/write transactions over a valid/ready request interface.
- Drives its slot's driver_value/driver_enable lanes for a fixed settle window, then samples the resolved bus.
- Returns the sampled data, plus a per-bit contention mask showing where another driver pulled a written 1 low.

Parameters:
- W, 8, bus width in bits (one bus_bit lane per bit).
- SETTLE, 2, cycles the slot is driven before the bus is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_write  input  1  1 = write req_data onto bus, 0 = read bus.
- req_data  input  W  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: response fields valid.
- rsp_data  output  W  resolved bus value sampled at end of settle window.
- rsp_conflict  output  W  per-bit contention mask (write only).
- conflict_count  output  8  saturating count of write transactions with nonzero conflict.
- drv_value  output  W  this slot's driver_value bits to the bus lanes.
- drv_enable  output  W  this slot's driver_enable bits to the bus lanes.
- bus_in  input  W  resolved bus value (output of the bus lanes).

Behaviour:
- All outputs are registered. One clock; synchronous active-high reset.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0.
  - rsp_data = 0, rsp_conflict = 0, conflict_count = 0.
  - drv_value = all ones, drv_enable = 0 (slot released).
- States: IDLE, DRIVE, RELEASE.
- IDLE:
  - req_ready = 1, drv_enable = 0, drv_value = all ones.
  - On an edge with req_valid & req_ready, latch req_write and req_data, load settle counter = SETTLE-1, go to DRIVE.
- DRIVE:
  - req_ready = 0.
  - Write: drv_value = latched data, drv_enable = all ones.
  - Read: drv_value = all ones, drv_enable = 0.
  - Counter decrements each cycle.
  - On the edge where counter = 0:
    - rsp_data <= bus_in.
    - rsp_conflict <= write ? (latched_data & ~bus_in) : 0.
    - If write and conflict is nonzero, conflict_count increments, saturating at 255.
    - rsp_valid <= 1, go to RELEASE.
- RELEASE:
  - drv_enable = 0, drv_value = all ones, req_ready = 0, rsp_valid = 1 for exactly this cycle.
  - Next edge: rsp_valid <= 0, go to IDLE.
- Latency: request accepted at edge E0.
  - drv_enable is active in cycles E0+1 .. E0+SETTLE.
  - rsp_valid is high in cycle E0+SETTLE+1.
  - Earliest next acceptance is the edge ending cycle E0+SETTLE+2, giving SETTLE+2 cycles per transaction.
- rsp_data and rsp_conflict hold their values after rsp_valid drops, until the next sample.
- Bus is always released for one full cycle between transactions (turnaround), so back-to-back writes never overlap.
- req_valid outside IDLE is ignored; the request stays pending until req_ready.
- Read never asserts drv_enable, so it cannot disturb the bus.
- A write of all ones is legal and behaves like a read with respect to the bus.
- Reset in any state (including mid-DRIVE) takes effect at that edge:
  - bus released, state IDLE, no response pulse, counter/latched data cleared.
  - conflict_count cleared.
- A reset asserted in the same cycle as req_valid wins; the request is not accepted.

Test Plan (W=8, SETTLE=2):
- Reset, then idle: reset high 2 cycles -> req_ready=1, drv_enable=0x00, drv_value=0xFF, rsp_valid=0, conflict_count=0.
- Uncontended write: req write 0xA5 at edge E0, bus_in follows drv_value -> drv_enable=0xFF for cycles E0+1..E0+2; rsp_valid only in E0+3; rsp_data=0xA5, rsp_conflict=0x00, count stays 0.
- Contended write: write 0xF0 while another driver forces bus_in=0x30 -> rsp_data=0x30, rsp_conflict=0xC0, conflict_count=1; repeat 300 times -> count saturates at 255.
- Read: bus_in=0x5A from external driver, req read -> drv_enable stays 0x00 throughout; rsp_valid at E0+3 with rsp_data=0x5A, rsp_conflict=0x00.
- Back-to-back with req_valid held high: two writes 0x11, 0x22 -> second accepted at E0+4; one RELEASE cycle with drv_enable=0x00 in between; two rsp_valid pulses, 4 cycles apart.
- Reset mid-DRIVE: assert reset in cycle E0+1 of a write -> next cycle drv_enable=0x00, state IDLE, no rsp_valid pulse, req_ready=1 once reset deasserts.
